// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
//
// Purpose:
//   Single-clock FIFO with parameterised width and depth. It provides
//   registered status flags, sticky overflow/underflow error flags, and an
//   optional show-ahead read mode.
//
// Parameters:
//   DATA_W    - data word width in bits
//   ADDR_W    - log2 of the depth (DEPTH = 2**ADDR_W)
//   AFULL_TH  - almost_full asserts when usedw >= AFULL_TH
//   AEMPTY_TH - almost_empty asserts when usedw <= AEMPTY_TH
//   SHOWAHEAD - 0: q loads the head word on an accepted read
//               1: q presents the head word whenever the FIFO is non-empty
//
// Ports:
//   clk          - sole clock; all state changes on its rising edge
//   rst_n        - synchronous active-low reset
//   flush        - synchronous clear of the contents; error flags are kept
//   clr_err      - clears the sticky overflow and underflow flags
//   wrreq, data  - write request and write data
//   rdreq        - read request
//   q            - read data
//   wrfull       - FIFO holds DEPTH words
//   rdempty      - FIFO holds no words
//   almost_full  - usedw >= AFULL_TH
//   almost_empty - usedw <= AEMPTY_TH
//   usedw        - current word count, 0..DEPTH
//   overflow     - sticky: a write was refused because the FIFO was full
//   underflow    - sticky: a read was attempted while the FIFO was empty
// ---------------------------------------------------------------------------
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int SHOWAHEAD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              clr_err,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] data,
  input  logic              rdreq,
  output logic [DATA_W-1:0] q,
  output logic              wrfull,
  output logic              rdempty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_LVL  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0]   AEMPTY_LVL = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_usedw;
  logic              r_wrfull;
  logic              r_rdempty;
  logic              r_almostFull;
  logic              r_almostEmpty;
  logic              r_overflow;
  logic              r_underflow;
  logic [DATA_W-1:0] r_q;

  logic              w_rdAcc;
  logic              w_wrAcc;
  logic              w_ovfEvent;
  logic              w_unfEvent;
  logic [ADDR_W:0]   w_usedwNext;

  // Accept logic. A write into a full FIFO still succeeds when a read
  // frees a slot in the same cycle. A flush cycle ignores both requests,
  // so it can neither move data nor raise an error.
  always_comb begin
    w_rdAcc    = rdreq && !r_rdempty && !flush;
    w_wrAcc    = wrreq && (!r_wrfull || w_rdAcc) && !flush;
    w_ovfEvent = wrreq && r_wrfull && !rdreq && !flush;
    w_unfEvent = rdreq && r_rdempty && !flush;
  end

  // Next word count. The status flags are derived from this value so that
  // the registered flags always agree with the registered count.
  always_comb begin
    w_usedwNext = r_usedw;
    if (flush) begin
      w_usedwNext = '0;
    end else if (w_wrAcc && !w_rdAcc) begin
      w_usedwNext = r_usedw + CNT_ONE;
    end else if (w_rdAcc && !w_wrAcc) begin
      w_usedwNext = r_usedw - CNT_ONE;
    end
  end

  // Storage array. It has no reset. Writes are blocked while rst_n is
  // low so that reset fully overrides any request.
  always_ff @(posedge clk) begin
    if (rst_n && w_wrAcc) begin
      r_mem[r_wrPtr] <= data;
    end
  end

  // Pointers, count, status flags and sticky errors.
  // An error event in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_usedw       <= '0;
      r_wrfull      <= 1'b0;
      r_rdempty     <= 1'b1;
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      if (flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
      end else begin
        if (w_wrAcc) r_wrPtr <= r_wrPtr + PTR_ONE;
        if (w_rdAcc) r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      r_usedw       <= w_usedwNext;
      r_wrfull      <= (w_usedwNext == DEPTH_LVL);
      r_rdempty     <= (w_usedwNext == '0);
      r_almostFull  <= (w_usedwNext >= AFULL_LVL);
      r_almostEmpty <= (w_usedwNext <= AEMPTY_LVL);
      r_overflow    <= (r_overflow && !clr_err) || w_ovfEvent;
      r_underflow   <= (r_underflow && !clr_err) || w_unfEvent;
    end
  end

  // Read data register. In normal mode it captures the head word on an
  // accepted read and holds it otherwise. In show-ahead mode it never
  // loads, so it stays at its reset value and only supplies q while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if ((SHOWAHEAD == 0) && w_rdAcc) begin
      r_q <= r_mem[r_rdPtr];
    end
  end

  // In show-ahead mode the head word is presented directly from the array.
  // It becomes valid in the same cycle that rdempty deasserts, because the
  // word was written on that same edge.
  assign q            = ((SHOWAHEAD != 0) && !r_rdempty) ? r_mem[r_rdPtr] : r_q;
  assign wrfull       = r_wrfull;
  assign rdempty      = r_rdempty;
  assign almost_full  = r_almostFull;
  assign almost_empty = r_almostEmpty;
  assign usedw        = r_usedw;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
